cdc_handshake_tx: RTL and testbench

Source-side endpoint of a four-phase req/ack bus crossing. It accepts a word on a valid/ready interface and holds it stable on `data_out`. It then raises `req_out` and waits for the destination's `ack_in`, which it synchronizes internally, to rise and then fall before accepting the next word. It sits in the sending clock domain. The destination domain samples `req_out` through its own synchronizer and latches `data_out`. Multi-bit data never passes through a flop-chain synchronizer.

---
 rtl/cdc_pkg.sv | 17 +
 rtl/sync_ff_n.sv | 28 ++
 rtl/cdc_handshake_tx.sv | 124 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types for the four-phase req/ack crossing.
//   hs_state_t : handshake FSM states
//   cnt_width  : bit width needed to count from 0 up to a given maximum
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETUP       = 2'd1,
        WAIT_ACK_HI = 2'd2,
        WAIT_ACK_LO = 2'd3
    } hs_state_t;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sync_ff_n.sv
// N-stage single-bit synchronizer for an asynchronous level input.
// Ports:
//   clk_in   : destination clock
//   rst_n_in : asynchronous active-low reset, clears every stage
//   d_in     : asynchronous input
//   q_out    : synchronized output (last stage)
module sync_ff_n #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out
);

    (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_in};
        end
    end

    assign q_out = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack crossing. A word accepted on the
// valid/ready side is held on data_out for the whole handshake; the
// destination samples req_out and latches data_out, so only the single-bit
// ack passes through a synchronizer.
// Ports:
//   clk_in, rst_n_in : clock and asynchronous active-low reset
//   data_in/valid_in/ready_out : producer interface
//   data_out    : held word for the destination domain
//   req_out     : registered four-phase request
//   ack_in      : four-phase acknowledge, asynchronous to clk_in
//   done_out    : one-cycle pulse when ack has returned low
//   timeout_out : sticky flag, an ack phase lasted TIMEOUT cycles
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SYNC_DEPTH = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic             req_out,
    input  logic             ack_in,
    output logic             done_out,
    output logic             timeout_out
);

    localparam int unsigned    CntW   = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    hs_state_t        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ack_s;
    logic             waiting;

    sync_ff_n #(
        .DEPTH (SYNC_DEPTH)
    ) u_ack_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (ack_in),
        .q_out    (ack_s)
    );

    assign waiting = (state_q == WAIT_ACK_HI) || (state_q == WAIT_ACK_LO);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    data_d  = data_in;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // data_out has had a full cycle to settle before req rises
                req_d   = 1'b1;
                state_d = WAIT_ACK_HI;
            end
            WAIT_ACK_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_ACK_LO;
                end
            end
            WAIT_ACK_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase

        // Timeout only flags; the FSM keeps waiting so four-phase order holds
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (waiting && (state_d == state_q) && (cnt_d == CntMax)) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_out   = (state_q == IDLE);
    assign data_out    = data_q;
    assign req_out     = req_q;
    assign done_out    = done_q;
    assign timeout_out = tmo_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomized bench for cdc_handshake_tx. The reference model is an event
// timeline: for each word it computes, from the acceptance edge and the
// destination's ack delays, the cycle on which req rises and falls, done
// pulses and timeout sets, then compares every cycle against it.
module tb_cdc_handshake_tx;

    localparam int SD  = 2;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [7:0] data_out;
    logic       req_out;
    logic       ack_in = 1'b0;
    logic       done_out;
    logic       timeout_out;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  tmo_exp  = 1'b0;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .WIDTH      (8),
        .SYNC_DEPTH (SD),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .req_out     (req_out),
        .ack_in      (ack_in),
        .done_out    (done_out),
        .timeout_out (timeout_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge with reset released.
    task automatic do_reset();
        valid_in = 1'b0;
        ack_in   = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("rst_ready", 32'(ready_out), 32'(1));
        check("rst_req", 32'(req_out), 32'(0));
        check("rst_done", 32'(done_out), 32'(0));
        check("rst_tmo", 32'(timeout_out), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        tmo_exp = 1'b0;
    endtask

    // One word. hi_dly/lo_dly: cycles the destination waits after req rises /
    // falls before moving ack. hold keeps valid_in high with nxt on data_in.
    task automatic xfer(input logic [7:0] d, input int hi_dly, input int lo_dly,
                        input bit hold, input logic [7:0] nxt, input bit glitch);
        int n;
        int t_f;
        int t_d;
        n = 0;
        while (!ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(ready_out), 32'(1));
        data_in  = d;
        valid_in = 1'b1;
        // Edge offsets from acceptance edge E0
        t_f = 2 + hi_dly + SD;
        t_d = t_f + lo_dly + SD + 1;
        for (int k = 0; k <= t_d; k++) begin
            @(posedge clk);
            if (glitch && !ack_in && ($urandom_range(0, 1) == 1)) begin
                #2 ack_in = 1'b1;
                #2 ack_in = 1'b0;
            end
            @(negedge clk);
            if (k == 0) begin
                if (hold) data_in = nxt;
                else valid_in = 1'b0;
            end
            if (k == 1 + hi_dly) ack_in = 1'b1;
            if (k == t_f + lo_dly) ack_in = 1'b0;
            if (k == 1 + TMO && t_f >= TMO + 2) tmo_exp = 1'b1;
            if (k == t_f + TMO && t_d >= t_f + TMO + 1) tmo_exp = 1'b1;
            check("data_out", 32'(data_out), 32'(d));
            check("ready_out", 32'(ready_out), 32'(k == t_d));
            check("req_out", 32'(req_out), 32'(k >= 1 && k < t_f));
            check("done_out", 32'(done_out), 32'(k == t_d));
            check("timeout_out", 32'(timeout_out), 32'(tmo_exp));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;

        #3;
        check("por_ready", 32'(ready_out), 32'(1));
        check("por_req", 32'(req_out), 32'(0));
        check("por_data", 32'(data_out), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transfer, destination answers after 3 cycles each way
        xfer(8'hA5, 3, 3, 1'b0, 8'h00, 1'b0);

        // Back-to-back words with valid held high throughout
        xfer(8'h01, 0, 0, 1'b1, 8'h02, 1'b0);
        xfer(8'h02, 1, 2, 1'b1, 8'h03, 1'b0);
        xfer(8'h03, 0, 0, 1'b0, 8'h00, 1'b0);

        // Next word waiting on data_in through a long WAIT_ACK_LO
        xfer(8'h5A, 2, 7, 1'b1, 8'hC3, 1'b0);
        xfer(8'hC3, 0, 1, 1'b0, 8'h00, 1'b0);

        // Randomized delays and data
        cur = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            nxt = 8'($urandom);
            xfer(cur, int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                 (i != 39) && ($urandom_range(0, 1) == 1), nxt, 1'b0);
            cur = nxt;
        end

        // Sub-cycle ack glitches must never be seen
        for (int i = 0; i < 200; i++) begin
            nxt = 8'($urandom);
            xfer(cur, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 (i != 199) && ($urandom_range(0, 1) == 1), nxt, 1'b1);
            cur = nxt;
        end

        // Ack stuck low past TIMEOUT, then completes; flag is sticky
        xfer(8'h77, 20, 2, 1'b0, 8'h00, 1'b0);
        xfer(8'h11, 1, 1, 1'b0, 8'h00, 1'b0);
        check("tmo_sticky", 32'(timeout_out), 32'(1));

        // Timeout while waiting for ack to fall
        do_reset();
        xfer(8'h22, 0, 20, 1'b0, 8'h00, 1'b0);

        // Reset mid-cycle while in WAIT_ACK_HI
        do_reset();
        data_in  = 8'h3C;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("pre_rst_req", 32'(req_out), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(req_out), 32'(0));
        check("async_rst_ready", 32'(ready_out), 32'(1));
        check("async_rst_data", 32'(data_out), 32'(0));
        check("async_rst_tmo", 32'(timeout_out), 32'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        tmo_exp = 1'b0;
        @(negedge clk);
        xfer(8'h96, 2, 2, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
